// File: rtl/chimera_apb_to_reg_if.sv
// APB completer bus plus reg-interface request bus for chimera_apb_to_reg.
// The slave modport is the bridge's view; master is the view of whatever
// drives APB and models the reg target.
interface chimera_apb_to_reg_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic [AddrWidth-1:0]   paddr_i;
  logic                   psel_i;
  logic                   penable_i;
  logic                   pwrite_i;
  logic [DataWidth-1:0]   pwdata_i;
  logic [DataWidth/8-1:0] pstrb_i;
  logic                   pready_o;
  logic [DataWidth-1:0]   prdata_o;
  logic                   pslverr_o;
  logic                   reg_valid_o;
  logic                   reg_write_o;
  logic [AddrWidth-1:0]   reg_addr_o;
  logic [DataWidth-1:0]   reg_wdata_o;
  logic [DataWidth/8-1:0] reg_wstrb_o;
  logic                   reg_ready_i;
  logic [DataWidth-1:0]   reg_rdata_i;
  logic                   reg_error_i;
  logic                   timeout_o;

  modport slave (
    input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    output pready_o, prdata_o, pslverr_o,
    output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
    input  reg_ready_i, reg_rdata_i, reg_error_i,
    output timeout_o
  );

  modport master (
    output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
    input  pready_o, prdata_o, pslverr_o,
    input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o,
    output reg_ready_i, reg_rdata_i, reg_error_i,
    input  timeout_o
  );
endinterface

// File: rtl/chimera_apb_to_reg.sv
// APB completer that forwards each transfer as a single reg-bus request.
// A request is issued the cycle after the APB setup phase, held until the
// target answers or the timeout limit forces an error completion, and the
// captured response is returned in the following APB access cycle.
module chimera_apb_to_reg #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  chimera_apb_to_reg_if.slave   bus
);
  localparam int          StrbWidth = DataWidth / 8;
  localparam logic [15:0] CntLimit  = 16'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   strb_q, strb_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   abort_q, abort_d;   // psel seen low during REQ
  logic                   timeout_q, timeout_d;
  logic                   drop;               // response must be discarded

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      timeout_q <= timeout_d;
    end
  end

  assign drop = abort_q | ~bus.psel_i;

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        // An access phase without a preceding setup is ignored here.
        if (bus.psel_i && !bus.penable_i) begin
          addr_d  = bus.paddr_i;
          write_d = bus.pwrite_i;
          wdata_d = bus.pwdata_i;
          strb_d  = bus.pwrite_i ? bus.pstrb_i : '0;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!bus.psel_i) abort_d = 1'b1;
        // A response on the limit cycle still counts as a normal completion.
        if (bus.reg_ready_i) begin
          rdata_d = write_q ? '0 : bus.reg_rdata_i;
          err_d   = bus.reg_error_i;
          state_d = drop ? IDLE : RESP;
        end else if (cnt_q == CntLimit) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = drop ? IDLE : RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reg side comes straight from registers; APB response gated to the
  // completing access cycle so read data never leaks into other cycles.
  assign bus.reg_valid_o = (state_q == REQ);
  assign bus.reg_write_o = write_q;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_wstrb_o = strb_q;
  assign bus.pready_o    = (state_q == RESP) && bus.psel_i && bus.penable_i;
  assign bus.prdata_o    = bus.pready_o ? rdata_q : '0;
  assign bus.pslverr_o   = bus.pready_o & err_q;
  assign bus.timeout_o   = timeout_q;
endmodule

// File: doc/chimera_apb_to_reg.md
Name: chimera_apb_to_reg

Overview:
APB completer that turns incoming APB transfers into register-bus requests towards a reg-interface peripheral. It is the responder-side counterpart of the SoC's reg-to-APB bridge. It lets a reg-interface block, such as a top-level configuration register file, sit behind the chip's external APB port. A request FSM inserts wait states, and a timeout counter guarantees APB completion when the reg target never responds.

Parameters:
AddrWidth, 32, width of paddr_i and reg_addr_o
DataWidth, 32, width of APB and reg data buses (multiple of 8)
TimeoutCycles, 255, maximum reg_valid_o cycles without reg_ready_i before a forced error completion (must be >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
paddr_i  in  AddrWidth  APB address
psel_i  in  1  APB select
penable_i  in  1  APB access phase
pwrite_i  in  1  1=write, 0=read
pwdata_i  in  DataWidth  APB write data
pstrb_i  in  DataWidth/8  APB write strobes
pready_o  out  1  APB transfer completion
prdata_o  out  DataWidth  APB read data
pslverr_o  out  1  APB error
reg_valid_o  out  1  reg request valid
reg_write_o  out  1  reg write enable
reg_addr_o  out  AddrWidth  reg address
reg_wdata_o  out  DataWidth  reg write data
reg_wstrb_o  out  DataWidth/8  reg byte strobes
reg_ready_i  in  1  reg response valid / accept
reg_rdata_i  in  DataWidth  reg read data
reg_error_i  in  1  reg error
timeout_o  out  1  one-cycle pulse on forced timeout completion

Behaviour:
- Reset (rst_i=1, async): FSM=IDLE; all outputs 0; latched addr/data/strb/rdata/err and timeout counter cleared. Reset mid-transfer abandons it with no reg or APB completion.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On a setup phase (psel_i=1, penable_i=0), latch paddr/pwrite/pwdata.
  - Latch strobes as pstrb_i for writes and all-zero for reads.
  - Next state REQ.
  - psel_i=1 with penable_i=1 while in IDLE is a protocol violation: ignore it and keep pready_o=0.
- REQ:
  - reg_valid_o=1, with reg_* driven from the latched registers (stable for the whole state).
  - On reg_ready_i=1, capture reg_rdata_i (force it to 0 for writes) and reg_error_i, then go to RESP. reg_valid_o drops the next cycle.
  - Timeout counter increments each REQ cycle without ready. If the counter equals TimeoutCycles-1 and reg_ready_i=0:
    - deassert reg_valid_o;
    - set captured err=1 and rdata=0;
    - pulse timeout_o for 1 cycle;
    - go to RESP.
  - reg_ready_i in the same cycle as the timeout limit wins as a normal response, with no timeout.
  - psel_i dropping during REQ does not abort the reg transaction. Finish it, then discard the response by going to IDLE instead of RESP.
- RESP:
  - pready_o=1 only while psel_i=1 and penable_i=1. prdata_o and pslverr_o carry the captured values in that cycle and are 0 in every other cycle.
  - Next state is IDLE after that cycle.
  - If psel_i=0 in RESP, go to IDLE without asserting pready_o.
- Latency: setup at cycle T, reg_valid_o at T+1. If ready arrives at T+1, pready_o=1 at T+2. Minimum APB transfer is 3 cycles (1 wait state). Each extra reg wait cycle adds 1 cycle.
- Back-to-back: a new setup phase is accepted in the cycle after pready_o (IDLE), with no bubble beyond that.
- Timeout counter is 16 bits wide, reset on entry to REQ, and saturates. It never wraps within one transfer.
- Only one outstanding transfer at any time. No combinational path from APB inputs to reg outputs; reg outputs come from registers only.

Test Plan:
- Write, zero-wait target: paddr=0x40, pwdata=0xA5A5_0F0F, pstrb=0xF, reg_ready_i tied 1 -> reg_valid_o=1 one cycle at T+1 with write=1, addr=0x40, wstrb=0xF; pready_o=1 at T+2, pslverr_o=0.
- Read with 4 target wait cycles: reg_rdata_i=0x1234_5678 at ready -> pready_o at T+6, prdata_o=0x1234_5678; prdata_o=0 in all other cycles.
- Error response: read of 0x80, reg_error_i=1 with ready -> pslverr_o=1 in the pready_o cycle only.
- Timeout: TimeoutCycles=8, reg_ready_i held 0 -> reg_valid_o high exactly 8 cycles; timeout_o pulses once; pready_o=1 with pslverr_o=1 and prdata_o=0.
- Ready coinciding with the timeout limit: TimeoutCycles=8, ready on the 8th REQ cycle -> normal completion, timeout_o=0, pslverr_o=0.
- Async reset asserted in REQ, then 3 back-to-back writes after release -> all outputs 0 during reset; each write completes in 3 cycles with correct addr/data and no residual state.
